disp_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an NDIG-digit common-segment 7-segment display on the I/O bus. It holds one 4-bit value per digit, written by the CPU output port. Per scan slot it feeds that value to the shared BCD-to-7-segment decoder and drives the decoder's segment pattern onto the display. It enables one digit at a time, with a blanking gap between digits to suppress ghosting.

---
 rtl/disp_scan_ctrl_if.sv | 12 +
 rtl/disp_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_disp_scan_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/disp_scan_ctrl_if.sv
// CPU-side digit write port of the display scan controller.
// The master drives one-cycle write strobes; the scan controller is the slave.
interface disp_scan_ctrl_if #(
    parameter int unsigned AW = 2
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [3:0]    wdata;

    modport master (output we, output waddr, output wdata);
    modport slave  (input  we, input  waddr, input  wdata);
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit 7-segment display:
// holds per-digit values, feeds a shared decoder, and scans with a blanking gap.
module disp_scan_ctrl #(
    parameter int unsigned NDIG  = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    disp_scan_ctrl_if.slave    wr,
    output logic [3:0]         dec_d,
    input  logic [7:0]         dec_q,
    output logic [7:0]         seg,
    output logic [NDIG-1:0]    an,
    output logic               slot_tick
);

    localparam int unsigned CW   = 16;
    localparam int unsigned NREG = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [3:0]      digit_q [NREG];
    logic [3:0]      digit_d [NREG];
    logic [7:0]      seg_q, seg_d;
    logic [NDIG-1:0] an_q, an_d;
    logic            tick_q, tick_d;

    // State, counters, digit storage and registered display drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= '0;
            an_q    <= '0;
            tick_q  <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
            for (int i = 0; i < int'(NREG); i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    // Next-state, slot sequencing and next-cycle display outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        an_d    = '0;
        seg_d   = '0;
        tick_d  = 1'b0;
        for (int i = 0; i < int'(NREG); i++) begin
            digit_d[i] = digit_q[i];
        end

        if (wr.we && (32'(wr.waddr) < NDIG)) begin
            digit_d[wr.waddr] = wr.wdata;
        end

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(BLANK - 1)) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CW'(DIV - 1)) begin
                        cnt_d   = '0;
                        idx_d   = (idx_q == AW'(NDIG - 1)) ? '0 : idx_q + AW'(1);
                        state_d = ST_BLANK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // Decoder output is captured on entry to SHOW so the first lit cycle is never stale
        if (state_d == ST_SHOW) begin
            an_d   = NDIG'(1) << idx_d;
            seg_d  = dec_q;
            tick_d = (cnt_d == CW'(DIV - 1));
        end
    end

    assign dec_d     = digit_q[idx_q];
    assign seg       = seg_q;
    assign an        = an_q;
    assign slot_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a 4-digit and a 3-digit instance share stimulus
// and are checked every cycle against a frame-position reference model.
module tb_disp_scan_ctrl;

    localparam int unsigned DIV   = 10;
    localparam int unsigned BLANK = 2;
    localparam int unsigned AW    = 2;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic           en    = 1'b0;
    logic           we    = 1'b0;
    logic [AW-1:0]  waddr = '0;
    logic [3:0]     wdata = '0;

    logic [3:0] dec_d0, dec_d1;
    logic [7:0] dec_q0, dec_q1, seg0, seg1;
    logic [3:0] an0;
    logic [2:0] an1;
    logic       tick0, tick1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0][7:0] an;
        logic [1:0][7:0] seg;
        logic [1:0]      tk;
        logic [1:0][3:0] dd;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    // Shared BCD-to-7-segment decoder (dp,g..a); 10-15 show a dash
    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0: seg7 = 8'h3F;
            4'd1: seg7 = 8'h06;
            4'd2: seg7 = 8'h5B;
            4'd3: seg7 = 8'h4F;
            4'd4: seg7 = 8'h66;
            4'd5: seg7 = 8'h6D;
            4'd6: seg7 = 8'h7D;
            4'd7: seg7 = 8'h07;
            4'd8: seg7 = 8'h7F;
            4'd9: seg7 = 8'h6F;
            default: seg7 = 8'h40;
        endcase
    endfunction

    assign dec_q0 = seg7(dec_d0);
    assign dec_q1 = seg7(dec_d1);

    disp_scan_ctrl_if #(.AW(AW)) wr0 ();
    disp_scan_ctrl_if #(.AW(AW)) wr1 ();
    assign wr0.we = we;  assign wr0.waddr = waddr;  assign wr0.wdata = wdata;
    assign wr1.we = we;  assign wr1.waddr = waddr;  assign wr1.wdata = wdata;

    disp_scan_ctrl #(.NDIG(4), .AW(AW), .DIV(DIV), .BLANK(BLANK)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .wr(wr0),
        .dec_d(dec_d0), .dec_q(dec_q0), .seg(seg0), .an(an0), .slot_tick(tick0)
    );

    disp_scan_ctrl #(.NDIG(3), .AW(AW), .DIV(DIV), .BLANK(BLANK)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .wr(wr1),
        .dec_d(dec_d1), .dec_q(dec_q1), .seg(seg1), .an(an1), .slot_tick(tick1)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: display position follows from the count of enabled edges
    initial begin
        int unsigned run;
        logic [3:0]  mdig [2][8];
        run = 0;
        for (int l = 0; l < 2; l++) for (int i = 0; i < 8; i++) mdig[l][i] = 4'd0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                run = 0;
                for (int l = 0; l < 2; l++) for (int i = 0; i < 8; i++) mdig[l][i] = 4'd0;
            end else begin
                exp_t        e;
                int unsigned slot [2];
                e = '0;
                run = en ? run + 1 : 0;
                for (int l = 0; l < 2; l++) begin
                    int unsigned nd, p, off;
                    nd = (l == 0) ? 4 : 3;
                    slot[l] = 0;
                    if (run > 0) begin
                        p       = run - 1;
                        slot[l] = (p / DIV) % nd;
                        off     = p % DIV;
                        if (off >= BLANK) begin
                            e.an[l]  = 8'(1 << slot[l]);
                            e.seg[l] = seg7(mdig[l][slot[l]]);
                            e.tk[l]  = (off == DIV - 1);
                        end
                    end
                    if (we && (int'(waddr) < int'(nd))) mdig[l][waddr] = wdata;
                    e.dd[l] = mdig[l][slot[l]];
                end
                sbq.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs against queued expectations away from the clock edge
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (sbq.size() != 0) void'(sbq.pop_front());
                chk("rst_an4",  8'(an0), 8'h00);
                chk("rst_seg4", seg0,    8'h00);
                chk("rst_an3",  8'(an1), 8'h00);
                chk("rst_tick", 8'({tick1, tick0}), 8'h00);
                chk("rst_decd", 8'({dec_d1, dec_d0}), 8'h00);
            end else if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("an4",   8'(an0),   e.an[0]);
                chk("seg4",  seg0,      e.seg[0]);
                chk("tick4", 8'(tick0), 8'(e.tk[0]));
                chk("decd4", 8'(dec_d0), 8'(e.dd[0]));
                chk("an3",   8'(an1),   e.an[1]);
                chk("seg3",  seg1,      e.seg[1]);
                chk("tick3", 8'(tick1), 8'(e.tk[1]));
                chk("decd3", 8'(dec_d1), 8'(e.dd[1]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [3:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    // Advance until the 4-digit instance lights the digit in 'want' (0 = any digit)
    task automatic wait_lit(input logic [3:0] want, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if ((want == 4'd0 && an0 != 4'd0) || (want != 4'd0 && an0 == want)) ok = 1'b1;
            else step();
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s actual=an:%b required=an:%b (timeout)", nm, an0, want);
        end
    endtask

    initial begin
        int sel;
        #1 reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Idle with display disabled
        repeat (50) step();

        // Load 1,2,3,4 and scan two full frames
        wr(2'd0, 4'd1); wr(2'd1, 4'd2); wr(2'd2, 4'd3); wr(2'd3, 4'd4);
        en = 1'b1;
        repeat (90) step();

        // Dash written to the lit digit mid-slot
        wait_lit(4'd0, "wait_show");
        step();
        sel = 0;
        for (int i = 0; i < 4; i++) if (an0[i]) sel = i;
        wr(AW'(sel), 4'hA);
        repeat (30) step();

        // Disable in the middle of digit 2, then resume from digit 0
        wait_lit(4'b0100, "wait_idx2");
        repeat (3) step();
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        repeat (60) step();

        // Asynchronous reset between edges while lit
        wait_lit(4'd0, "wait_show_rst");
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_an4",  8'(an0), 8'h00);
        chk("async_seg4", seg0,    8'h00);
        chk("async_an3",  8'(an1), 8'h00);
        chk("async_seg3", seg1,    8'h00);
        step();
        reset = 1'b0;
        repeat (60) step();

        // Randomized writes and enable drops
        for (int c = 0; c < 3000; c++) begin
            we    = ($urandom_range(0, 3) == 0);
            waddr = AW'($urandom);
            wdata = 4'($urandom);
            if (!en) en = 1'b1;
            else if ($urandom_range(0, 149) == 0) en = 1'b0;
            step();
        end
        we = 1'b0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
